// File: rtl/cache_bus_master_pkg.sv
// Shared definitions for cache_bus_master: one-hot state encodings, line/beat geometry
// and the per-beat SIZE helper.
package cache_bus_master_pkg;

    localparam int LINE_BYTES     = 16;
    localparam int BEAT_BYTES     = 4;
    localparam int BEATS_PER_LINE = LINE_BYTES / BEAT_BYTES;
    localparam int TIMEOUT_W      = 8;

    typedef enum logic [6:0] {
        ST_IDLE    = 7'b0000001,
        ST_ARB     = 7'b0000010,
        ST_ADDR    = 7'b0000100,
        ST_WDATA   = 7'b0001000,
        ST_WAIT_RD = 7'b0010000,
        ST_RDATA   = 7'b0100000,
        ST_RESP    = 7'b1000000
    } state_t;

    // Bytes still to move at the start of the given beat.
    function automatic logic [11:0] beat_size(input logic [1:0] beat);
        beat_size = 12'(LINE_BYTES) - (12'(BEAT_BYTES) * {10'd0, beat});
    endfunction

endpackage

// File: rtl/cache_bus_master_bus_beat_buffer.sv
// bus_beat_buffer: beat counter, read-line capture register and write-word select mux
// shared by the write and read data phases of cache_bus_master.
module bus_beat_buffer
    import cache_bus_master_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         beat_clear,
    input  logic         beat_advance,
    input  logic         line_clear,
    input  logic         capture,
    input  logic [31:0]  din,
    input  logic [127:0] wline,
    output logic [1:0]   beat,
    output logic         last_beat,
    output logic [31:0]  wword,
    output logic [127:0] rline
);

    logic [1:0]   beat_r;
    logic [127:0] line_r;

    // Beat index within the current line; wraps back to 0 after the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_r <= 2'd0;
        end else if (beat_clear) begin
            beat_r <= 2'd0;
        end else if (beat_advance) begin
            beat_r <= beat_r + 2'd1;
        end else begin
            beat_r <= beat_r;
        end
    end

    // Read line assembly: each captured beat lands in its own 32-bit slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_r <= 128'd0;
        end else if (line_clear) begin
            line_r <= 128'd0;
        end else if (capture) begin
            line_r[{beat_r, 5'd0} +: 32] <= din;
        end else begin
            line_r <= line_r;
        end
    end

    // Write word selection for the current beat.
    always_comb begin
        wword = 32'd0;
        case (beat_r)
            2'd0:    wword = wline[31:0];
            2'd1:    wword = wline[63:32];
            2'd2:    wword = wline[95:64];
            2'd3:    wword = wline[127:96];
            default: wword = 32'd0;
        endcase
    end

    assign beat      = beat_r;
    assign last_beat = (beat_r == 2'(BEATS_PER_LINE - 1));
    assign rline     = line_r;

endmodule

// File: rtl/cache_bus_master.sv
// cache_bus_master: turns one cache line request into an arbitrated shared-bus transfer.
// Optional read watchdog enabled by defining CACHE_BUS_TIMEOUT_EN.
module cache_bus_master
    import cache_bus_master_pkg::*;
(
    input  logic              BUS_CLK,
    input  logic              RST,
    inout  wire logic [31:0]  D,
    inout  wire logic [15:0]  A,
    inout  wire logic [11:0]  SIZE,
    inout  wire logic         RW,
    output logic              BR,
    input  logic              BG,
    input  logic              ACK_IN,
    output logic              ACK_OUT,
    input  logic              DEST_IN,
    input  logic              REQ_VALID,
    input  logic              REQ_RW,
    input  logic [15:0]       REQ_ADDR,
    input  logic [127:0]      REQ_WDATA,
    output logic              REQ_READY,
    output logic              RESP_VALID,
    output logic [127:0]      RESP_DATA,
    output logic              RESP_ERR
);

    state_t         state_r;
    state_t         state_s;
    logic           rw_r;
    logic [15:0]    addr_r;
    logic [127:0]   wdata_r;

    logic           accept_s;
    logic           timeout_s;
    logic           err_s;
    logic           drive_addr_s;
    logic           drive_data_s;
    logic           beat_clear_s;
    logic           beat_advance_s;
    logic           capture_s;
    logic           line_clear_s;
    logic [11:0]    size_s;
    logic [1:0]     beat_s;
    logic           last_beat_s;
    logic [31:0]    wword_s;
    logic [127:0]   rline_s;

    assign accept_s = REQ_VALID && (state_r == ST_IDLE);

`ifdef CACHE_BUS_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wait_cnt_r;
    logic                 err_r;

    // Consecutive cycles spent waiting for the returning read transfer.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            wait_cnt_r <= 8'd0;
        end else if (state_r == ST_WAIT_RD) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end

    assign timeout_s = (state_r == ST_WAIT_RD) && !DEST_IN && (wait_cnt_r == 8'd255);

    // Error flag reported with the response of a timed-out read.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            err_r <= 1'b0;
        end else if (accept_s) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_s = err_r;
`else
    assign timeout_s = 1'b0;
    assign err_s     = 1'b0;
`endif

    // State register.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DEST_IN only matters while a read is outstanding.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_ARB;
                else          state_s = ST_IDLE;
            end
            ST_ARB: begin
                if (BG) state_s = ST_ADDR;
                else    state_s = ST_ARB;
            end
            ST_ADDR: begin
                if (ACK_IN) state_s = rw_r ? ST_WDATA : ST_WAIT_RD;
                else        state_s = ST_ADDR;
            end
            ST_WDATA: begin
                if (last_beat_s) state_s = ST_RESP;
                else             state_s = ST_WDATA;
            end
            ST_WAIT_RD: begin
                if (DEST_IN)        state_s = ST_RDATA;
                else if (timeout_s) state_s = ST_RESP;
                else                state_s = ST_WAIT_RD;
            end
            ST_RDATA: begin
                if (last_beat_s) state_s = ST_RESP;
                else             state_s = ST_RDATA;
            end
            ST_RESP:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output and datapath control decoded from the registered state.
    always_comb begin
        REQ_READY      = 1'b0;
        BR             = 1'b0;
        ACK_OUT        = 1'b0;
        RESP_VALID     = 1'b0;
        RESP_ERR       = 1'b0;
        drive_addr_s   = 1'b0;
        drive_data_s   = 1'b0;
        beat_advance_s = 1'b0;
        capture_s      = 1'b0;
        case (state_r)
            ST_IDLE: REQ_READY = 1'b1;
            ST_ARB:  BR = 1'b1;
            ST_ADDR: begin
                BR           = 1'b1;
                drive_addr_s = 1'b1;
            end
            ST_WDATA: begin
                BR             = 1'b1;
                drive_addr_s   = 1'b1;
                drive_data_s   = 1'b1;
                beat_advance_s = 1'b1;
            end
            ST_WAIT_RD: begin
                BR = 1'b0;
            end
            ST_RDATA: begin
                ACK_OUT        = 1'b1;
                capture_s      = 1'b1;
                beat_advance_s = 1'b1;
            end
            ST_RESP: begin
                RESP_VALID = 1'b1;
                RESP_ERR   = err_s;
            end
            default: REQ_READY = 1'b0;
        endcase
    end

    // Request latch; the cache side may change its inputs once accepted.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            rw_r    <= 1'b0;
            addr_r  <= 16'd0;
            wdata_r <= 128'd0;
        end else if (accept_s) begin
            rw_r    <= REQ_RW;
            addr_r  <= REQ_ADDR;
            wdata_r <= REQ_WDATA;
        end else begin
            rw_r    <= rw_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Reads overwrite every word, so only writes and timeouts need an explicit clear.
    assign line_clear_s = (accept_s && REQ_RW) || timeout_s;
    assign beat_clear_s = (state_r == ST_IDLE);
    assign size_s       = (state_r == ST_WDATA) ? beat_size(beat_s) : 12'(LINE_BYTES);

    bus_beat_buffer u_beat_buffer (
        .clk          (BUS_CLK),
        .rst          (RST),
        .beat_clear   (beat_clear_s),
        .beat_advance (beat_advance_s),
        .line_clear   (line_clear_s),
        .capture      (capture_s),
        .din          (D),
        .wline        (wdata_r),
        .beat         (beat_s),
        .last_beat    (last_beat_s),
        .wword        (wword_s),
        .rline        (rline_s)
    );

    assign A         = drive_addr_s ? addr_r  : 16'hzzzz;
    assign RW        = drive_addr_s ? rw_r    : 1'bz;
    assign SIZE      = drive_addr_s ? size_s  : 12'hzzz;
    assign D         = drive_data_s ? wword_s : 32'hzzzz_zzzz;
    assign RESP_DATA = rline_s;

endmodule

// File: tb/tb_cache_bus_master.sv
// Self-checking bench for cache_bus_master: directed spec scenarios plus randomized
// transfers checked against a transaction-level model of the bus protocol.
module tb_cache_bus_master;

    logic         clk;
    logic         rst;
    logic         bg;
    logic         ack_in;
    logic         dest_in;
    logic         req_valid;
    logic         req_rw;
    logic [15:0]  req_addr;
    logic [127:0] req_wdata;
    logic         br;
    logic         ack_out;
    logic         req_ready;
    logic         resp_valid;
    logic [127:0] resp_data;
    logic         resp_err;
    logic         tb_d_en;
    logic [31:0]  tb_d;

    // Released bus lines float high, so high-Z reads back as all ones.
    tri1 [31:0] bus_d;
    tri1 [15:0] bus_a;
    tri1 [11:0] bus_size;
    tri1        bus_rw;

    assign bus_d = tb_d_en ? tb_d : 32'hzzzz_zzzz;

    int           n_cmp;
    int           n_fail;
    logic [127:0] last_line;

    cache_bus_master dut (
        .BUS_CLK    (clk),
        .RST        (rst),
        .D          (bus_d),
        .A          (bus_a),
        .SIZE       (bus_size),
        .RW         (bus_rw),
        .BR         (br),
        .BG         (bg),
        .ACK_IN     (ack_in),
        .ACK_OUT    (ack_out),
        .DEST_IN    (dest_in),
        .REQ_VALID  (req_valid),
        .REQ_RW     (req_rw),
        .REQ_ADDR   (req_addr),
        .REQ_WDATA  (req_wdata),
        .REQ_READY  (req_ready),
        .RESP_VALID (resp_valid),
        .RESP_DATA  (resp_data),
        .RESP_ERR   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // One complete transfer from IDLE back to IDLE; inputs change and outputs are sampled on negedges.
    task automatic run_txn(input logic rw, input logic [15:0] addr, input logic [127:0] wdata,
                           input int bg_d, input int ack_d, input int dest_d, input logic [127:0] rdata);
        logic [127:0] sh;
        logic [127:0] exp_line;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", req_ready); end
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata; bg = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; req_rw = ~rw; req_addr = ~addr; req_wdata = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i <= bg_d; i++) begin
            if (i == bg_d) bg = 1'b1;
            n_cmp++; if (br !== 1'b1) begin n_fail++; $display("FAIL arb_br: got %b want 1", br); end
            n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL arb_ready: got %b want 0", req_ready); end
            n_cmp++; if (bus_a !== 16'hffff) begin n_fail++; $display("FAIL arb_a_z: got %h want ffff", bus_a); end
            @(negedge clk);
        end
        for (int i = 0; i <= ack_d; i++) begin
            bg = 1'($urandom_range(0, 1));
            if (i == ack_d) ack_in = 1'b1;
            n_cmp++; if (bus_a !== addr) begin n_fail++; $display("FAIL addr_a: got %h want %h", bus_a, addr); end
            n_cmp++; if (bus_rw !== rw) begin n_fail++; $display("FAIL addr_rw: got %b want %b", bus_rw, rw); end
            n_cmp++; if (bus_size !== 12'd16) begin n_fail++; $display("FAIL addr_size: got %0d want 16", bus_size); end
            n_cmp++; if (br !== 1'b1) begin n_fail++; $display("FAIL addr_br: got %b want 1", br); end
            @(negedge clk);
        end
        ack_in = 1'b0;
        if (rw) begin
            for (int k = 0; k < 4; k++) begin
                bg = 1'($urandom_range(0, 1));
                sh = wdata >> (32 * k);
                n_cmp++; if (bus_d !== sh[31:0]) begin n_fail++; $display("FAIL wr_beat%0d_d: got %h want %h", k, bus_d, sh[31:0]); end
                n_cmp++; if (bus_size !== 12'(16 - 4 * k)) begin n_fail++; $display("FAIL wr_beat%0d_size: got %0d want %0d", k, bus_size, 16 - 4 * k); end
                n_cmp++; if (bus_a !== addr || bus_rw !== 1'b1 || br !== 1'b1) begin n_fail++; $display("FAIL wr_beat%0d_ctl: got a=%h rw=%b br=%b want a=%h rw=1 br=1", k, bus_a, bus_rw, br, addr); end
                n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_beat%0d_resp: got %b want 0", k, resp_valid); end
                @(negedge clk);
            end
            exp_line = 128'd0;
        end else begin
            bg = 1'b0;
            for (int i = 0; i <= dest_d; i++) begin
                if (i == dest_d) dest_in = 1'b1;
                n_cmp++; if (br !== 1'b0 || ack_out !== 1'b0) begin n_fail++; $display("FAIL wait_ctl: got br=%b ack=%b want 0 0", br, ack_out); end
                n_cmp++; if (bus_a !== 16'hffff || resp_valid !== 1'b0) begin n_fail++; $display("FAIL wait_bus: got a=%h rv=%b want ffff 0", bus_a, resp_valid); end
                @(negedge clk);
            end
            dest_in = 1'b0;
            tb_d_en = 1'b1;
            for (int k = 0; k < 4; k++) begin
                sh = rdata >> (32 * k);
                tb_d = sh[31:0];
                n_cmp++; if (ack_out !== 1'b1 || br !== 1'b0) begin n_fail++; $display("FAIL rd_beat%0d_ack: got ack=%b br=%b want 1 0", k, ack_out, br); end
                @(negedge clk);
            end
            tb_d_en = 1'b0;
            exp_line = rdata;
        end
        bg = 1'b0;
        n_cmp++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL resp_valid: got %b want 1", resp_valid); end
        n_cmp++; if (resp_data !== exp_line) begin n_fail++; $display("FAIL resp_data: got %h want %h", resp_data, exp_line); end
        n_cmp++; if (resp_err !== 1'b0 || br !== 1'b0 || ack_out !== 1'b0) begin n_fail++; $display("FAIL resp_ctl: got err=%b br=%b ack=%b want 0 0 0", resp_err, br, ack_out); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL resp_pulse: got rv=%b rdy=%b want 0 1", resp_valid, req_ready); end
        last_line = exp_line;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (br !== 1'b0 || ack_out !== 1'b0) begin n_fail++; $display("FAIL rst_br_ack: got %b %b want 0 0", br, ack_out); end
        n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_cache_side: got rdy=%b rv=%b err=%b want 1 0 0", req_ready, resp_valid, resp_err); end
        n_cmp++; if (bus_d !== 32'hffff_ffff || bus_a !== 16'hffff || bus_size !== 12'hfff || bus_rw !== 1'b1) begin n_fail++; $display("FAIL rst_bus_z: got d=%h a=%h size=%h rw=%b want released", bus_d, bus_a, bus_size, bus_rw); end
        n_cmp++; if (resp_data !== 128'd0) begin n_fail++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
        last_line = 128'd0;
        @(negedge clk);
    endtask

    task automatic test_read_directed();
        run_txn(1'b0, 16'h1230, 128'd0, 2, 1, 5, 128'h44444444_33333333_22222222_11111111);
    endtask

    task automatic test_write_directed();
        run_txn(1'b1, 16'h0040, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 0, 0, 0, 128'd0);
    endtask

    task automatic test_dest_ignored();
        tb_d_en = 1'b1;
        tb_d = 32'hDEAD_BEEF;
        dest_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (ack_out !== 1'b0 || resp_data !== last_line) begin n_fail++; $display("FAIL dest_idle: got ack=%b data=%h want 0 %h", ack_out, resp_data, last_line); end
        end
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h0100; bg = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (ack_out !== 1'b0 || br !== 1'b1 || resp_data !== last_line) begin n_fail++; $display("FAIL dest_arb: got ack=%b br=%b data=%h want 0 1 %h", ack_out, br, resp_data, last_line); end
            @(negedge clk);
        end
        dest_in = 1'b0;
        tb_d_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (br !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 128'd0) begin n_fail++; $display("FAIL dest_abort: got br=%b rdy=%b rv=%b data=%h want 0 1 0 0", br, req_ready, resp_valid, resp_data); end
        last_line = 128'd0;
    endtask

    task automatic test_reset_midwrite();
        logic [127:0] w;
        logic [127:0] sh;
        w = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h0BEE; req_wdata = w; bg = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        ack_in = 1'b1;
        @(negedge clk);
        ack_in = 1'b0; bg = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sh = w >> 64;
        n_cmp++; if (bus_d !== sh[31:0] || bus_size !== 12'd8) begin n_fail++; $display("FAIL midwr_beat2: got d=%h size=%0d want %h 8", bus_d, bus_size, sh[31:0]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (br !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL midwr_state: got br=%b rdy=%b rv=%b want 0 1 0", br, req_ready, resp_valid); end
        n_cmp++; if (bus_d !== 32'hffff_ffff || bus_a !== 16'hffff || bus_size !== 12'hfff) begin n_fail++; $display("FAIL midwr_bus_z: got d=%h a=%h size=%h want released", bus_d, bus_a, bus_size); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL midwr_no_resp: got %b want 0", resp_valid); end
        end
        last_line = 128'd0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            run_txn(1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom, $urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                    {$urandom, $urandom, $urandom, $urandom});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            run_txn(1'(n % 2), 16'($urandom), {$urandom, $urandom, $urandom, $urandom},
                    0, 0, 0, {$urandom, $urandom, $urandom, $urandom});
        end
    endtask

`ifdef CACHE_BUS_TIMEOUT_EN
    task automatic test_timeout();
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h7777; bg = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        ack_in = 1'b1;
        @(negedge clk);
        ack_in = 1'b0; bg = 1'b0;
        for (int i = 0; i < 256; i++) begin
            n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: got rv=%b want 0", i, resp_valid); end
            @(negedge clk);
        end
        n_cmp++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 128'd0) begin n_fail++; $display("FAIL to_resp: got rv=%b err=%b data=%h want 1 1 0", resp_valid, resp_err, resp_data); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL to_after: got rv=%b err=%b rdy=%b want 0 0 1", resp_valid, resp_err, req_ready); end
        last_line = 128'd0;
    endtask
`endif

    initial begin
        n_cmp = 0; n_fail = 0; last_line = 128'd0;
        rst = 1'b1; bg = 1'b0; ack_in = 1'b0; dest_in = 1'b0;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = 16'd0; req_wdata = 128'd0;
        tb_d_en = 1'b0; tb_d = 32'd0;
        test_reset();
        test_read_directed();
        test_dest_ignored();
        test_write_directed();
        test_reset_midwrite();
        test_random();
        test_back_to_back();
`ifdef CACHE_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
